// File: rtl/adder_pkg.sv
// Shared types and defaults for the 32-bit adder datapath and its result capture stage.
package adder_pkg;

  localparam int unsigned ADDER_W  = 32;
  localparam int unsigned RESULT_W = ADDER_W + 1;

  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned DEFAULT_ACC_W = 40;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef struct packed {
    logic               carry;
    logic [ADDER_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous power-of-two FIFO with registered storage; reads zero while empty.
module result_fifo
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adder_result_stage.sv
// Captures adder results into a FIFO and keeps accumulator, overflow and carry statistics.
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned ACC_W = DEFAULT_ACC_W,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDER_W-1:0]  sum_in,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_data,
  input  logic                clear,
  output logic [ACC_W-1:0]    acc,
  output logic                acc_ovf,
  output logic [CNT_W-1:0]    carry_cnt
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  result_t               res_in;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  unused_count;
  logic                  push, pop;

  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [SUM_W-1:0] acc_sum;

  assign res_in.carry = carry_in;
  assign res_in.sum   = sum_in;

  assign in_ready  = ~fifo_full & ~rst;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign unused_count = ^fifo_count;

  result_fifo #(
    .DATA_W (RESULT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (res_in),
    .pop_i   (pop),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Clear zeroes the statistics first, so a same-cycle push lands on a clean base.
  always_comb begin
    acc_base = clear ? '0 : acc_q;
    cnt_base = clear ? '0 : cnt_q;
    acc_sum  = {1'b0, acc_base} + SUM_W'(res_in);
    acc_d    = acc_base;
    ovf_d    = clear ? 1'b0 : ovf_q;
    cnt_d    = cnt_base;
    if (push) begin
      acc_d = acc_sum[ACC_W-1:0];
      ovf_d = ovf_d | acc_sum[ACC_W];
      if (carry_in && (cnt_base != CNT_MAX)) cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;
  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage: vector table plus hand-written corner sequences.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, carry_in, out_ready, clear;
  logic [31:0] sum_in;
  logic        in_ready, out_valid, acc_ovf;
  logic [32:0] out_data;
  logic [39:0] acc;
  logic [7:0]  carry_cnt;

  logic        d2_in_valid, d2_carry_in, d2_in_ready, d2_out_valid, d2_acc_ovf;
  logic [31:0] d2_sum_in;
  logic [32:0] d2_out_data;
  logic [39:0] d2_acc;
  logic [1:0]  d2_carry_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_result_stage #(.DEPTH(2), .ACC_W(40), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .clear(clear),
    .acc(acc), .acc_ovf(acc_ovf), .carry_cnt(carry_cnt)
  );

  adder_result_stage #(.DEPTH(2), .ACC_W(40), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .sum_in(d2_sum_in), .carry_in(d2_carry_in), .out_valid(d2_out_valid),
    .out_ready(1'b1), .out_data(d2_out_data), .clear(1'b0),
    .acc(d2_acc), .acc_ovf(d2_acc_ovf), .carry_cnt(d2_carry_cnt)
  );

  typedef struct {
    logic        vld;
    logic [31:0] sum;
    logic        cry;
    logic        ordy;
    logic        clr;
    logic        e_rdy;
    logic        e_oval;
    logic [32:0] e_odata;
    logic [39:0] e_acc;
    logic        e_ovf;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drain(input logic [31:0] s, input logic c);
    in_valid = 1'b1; sum_in = s; carry_in = c; out_ready = 1'b1; clear = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum_in = '0; carry_in = 1'b0; out_ready = 1'b0; clear = 1'b0;
    d2_in_valid = 1'b0; d2_sum_in = '0; d2_carry_in = 1'b0;

    // fields: vld sum cry ordy clr | rdy oval odata acc ovf cnt
    vecs[0]  = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 33'h1_FFFF_FFFF, 40'h01_FFFF_FFFF, 1'b0, 8'd1};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 33'h0,           40'h01_FFFF_FFFF, 1'b0, 8'd1};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 33'h0,           40'h0,            1'b0, 8'd0};
    vecs[3]  = '{1'b1, 32'h11,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 33'h0_0000_0011, 40'h11,           1'b0, 8'd0};
    vecs[4]  = '{1'b1, 32'h22,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 33'h0_0000_0011, 40'h01_0000_0033, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 32'h33,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 33'h0_0000_0011, 40'h01_0000_0033, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 32'h33,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 33'h1_0000_0022, 40'h01_0000_0033, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 32'h33,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 33'h0_0000_0033, 40'h01_0000_0066, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 32'h44,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 33'h0_0000_0033, 40'h01_0000_00AA, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 33'h0_0000_0044, 40'h01_0000_00AA, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 33'h0,           40'h01_0000_00AA, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 33'h0,           40'h0,            1'b0, 8'd0};
    vecs[12] = '{1'b1, 32'h123,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 33'h0_0000_0123, 40'h123,          1'b0, 8'd0};
    vecs[13] = '{1'b1, 32'h10,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 33'h0_0000_0123, 40'h01_0000_0010, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 33'h0_0000_0123, 40'h01_0000_0010, 1'b0, 8'd1};

    // Reset state
    repeat (2) step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_data", 64'(out_data), 64'd0);
    chk("post_rst_acc", 64'(acc), 64'd0);
    chk("post_rst_ovf", 64'(acc_ovf), 64'd0);
    chk("post_rst_cnt", 64'(carry_cnt), 64'd0);

    for (int i = 0; i < 15; i++) begin
      in_valid = vecs[i].vld; sum_in = vecs[i].sum; carry_in = vecs[i].cry;
      out_ready = vecs[i].ordy; clear = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_oval));
      chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_odata));
      chk($sformatf("v%0d_acc", i), 64'(acc), 64'(vecs[i].e_acc));
      chk($sformatf("v%0d_acc_ovf", i), 64'(acc_ovf), 64'(vecs[i].e_ovf));
      chk($sformatf("v%0d_carry_cnt", i), 64'(carry_cnt), 64'(vecs[i].e_cnt));
    end

    // Drain, clear, then walk the accumulator to 2^40-1 and across the wrap
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 128; i++) push_drain(32'hFFFF_FFFF, 1'b1);
    push_drain(32'h7F, 1'b0);
    chk("preload_acc", 64'(acc), 64'hFF_FFFF_FFFF);
    chk("preload_ovf", 64'(acc_ovf), 64'd0);
    chk("preload_cnt", 64'(carry_cnt), 64'd128);
    push_drain(32'h1, 1'b0);
    chk("wrap_acc", 64'(acc), 64'd0);
    chk("wrap_ovf", 64'(acc_ovf), 64'd1);
    push_drain(32'h5, 1'b0);
    chk("after_wrap_acc", 64'(acc), 64'd5);
    chk("sticky_ovf", 64'(acc_ovf), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ovf", 64'(acc_ovf), 64'd0);
    chk("clear_acc", 64'(acc), 64'd0);

    // Carry counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      d2_in_valid = 1'b1; d2_sum_in = 32'h0; d2_carry_in = 1'b1;
      step();
      chk($sformatf("sat_cnt_%0d", i), 64'(d2_carry_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    d2_in_valid = 1'b0;
    chk("sat_acc", 64'(d2_acc), 64'h5_0000_0000);

    // Reset with two entries buffered
    out_ready = 1'b0;
    push_drain(32'hAAAA_0001, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; sum_in = 32'hAAAA_0002; carry_in = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1; sum_in = 32'h77; carry_in = 1'b1; clear = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready_comb", 64'(in_ready), 64'd0);
    step();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_acc", 64'(acc), 64'd0);
    chk("rel_cnt", 64'(carry_cnt), 64'd0);
    step();
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Downstream capture stage for the 32-bit adder. It consumes the adder's 32-bit sum and carry-out as a 33-bit result word.
- Results enter through a valid/ready handshake and are buffered in a small FIFO before being handed to the consumer.
- On every accepted result it also updates a running accumulator, a sticky overflow flag and a saturating carry counter, for datapath statistics and checksum use.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- ACC_W, 40, accumulator width; at least 33.
- CNT_W, 8, carry-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a result is presented on sum_in/carry_in.
- in_ready  out  1  stage can accept a result this cycle.
- sum_in  in  32  adder sum S[31:0].
- carry_in  in  1  adder carry-out C32.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  33  head entry, packed as {carry, sum}.
- clear  in  1  synchronous clear of the statistics only.
- acc  out  ACC_W  running sum of accepted 33-bit results.
- acc_ovf  out  1  sticky accumulator-wrap flag.
- carry_cnt  out  CNT_W  number of accepted results with carry=1, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO empty; read and write pointers and occupancy count = 0.
  - out_valid=0, out_data=0, acc=0, acc_ovf=0, carry_cnt=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
  - Reset overrides clear and all handshakes. Reset mid-transfer discards buffered entries.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !full & !rst, where full means occupancy = DEPTH.
  - in_ready does not depend on out_ready, so there is no combinational ready path.
  - out_valid = occupancy != 0.
  - out_data is registered FIFO storage and is stable while out_valid=1 and out_ready=0.
  - out_data is 0 when the FIFO is empty.
- Latency: a result pushed at edge N is visible on out_data/out_valid after edge N. There is no bypass when the FIFO is empty.
- FIFO boundary cases:
  - Push and pop in the same cycle (only possible when not full): occupancy unchanged, both pointers advance.
  - Pop only: occupancy - 1. Push only: occupancy + 1.
  - Pointers wrap modulo DEPTH.
  - When full, in_ready=0, so a pop in that cycle does not enable a push in the same cycle.
  - Order is strictly first-in, first-out.
- Accumulator, updated on push:
  - acc <= (acc + zero-extended {carry_in, sum_in}) mod 2^ACC_W.
  - acc_ovf is set when that addition produces a carry out of bit ACC_W-1. It stays set until clear or rst.
- Carry counter: on push with carry_in=1, carry_cnt increments and saturates at 2^CNT_W - 1. It never wraps.
- clear:
  - Zeroes acc, acc_ovf and carry_cnt at the edge.
  - If a push occurs in the same cycle, clear applies first and then the push: acc <= {carry_in, sum_in}, acc_ovf <= 0, carry_cnt <= carry_in.
  - clear does not affect FIFO contents or the handshake signals.
- Statistics outputs are registered and reflect all pushes up to and including the previous edge.

Decomposition:
- Shared package adder_pkg holds:
  - ADDER_W = 32;
  - RESULT_W = ADDER_W + 1;
  - a packed result type {logic carry; logic [ADDER_W-1:0] sum};
  - default DEPTH/ACC_W/CNT_W constants.
- One sub-module, result_fifo: parameterised synchronous FIFO (data, push, pop, full, empty, count).
- The accumulator and counter stay in the top level.

Test Plan:
- Reset, then push sum=0xFFFFFFFF carry=1 with out_ready=0 → out_valid=1 next cycle, out_data=0x1_FFFFFFFF, acc=0x1FFFFFFFF, carry_cnt=1.
- Push 3 results with out_ready=0, DEPTH=2 → in_ready=0 after the 2nd push, the 3rd is held off; raise out_ready → heads pop in order 1st then 2nd, then the 3rd is accepted.
- FIFO has 1 entry, push and pop in the same cycle → occupancy stays 1, out_data shows the new entry, no loss or duplication.
- Preload acc via pushes totalling 0xFF_FFFFFFFF, then push sum=1 carry=0 → acc=0, acc_ovf=1; a further push of 5 → acc=5, acc_ovf still 1.
- CNT_W=2: push 5 results with carry=1 → carry_cnt goes 1, 2, 3, 3, 3.
- clear together with a push of {1, 0x00000010} while acc=0x123 → acc=0x100000010, carry_cnt=1, acc_ovf=0, FIFO occupancy increments.
- Assert rst with 2 entries buffered → out_valid=0 and in_ready=0 during reset; after release in_ready=1 and acc=0.
